// File: rtl/csa_bist_controller.sv
// csa_bist_controller: sequences one CSA TPG self-test session, compares CUT responses,
// and reports the error count plus the first failing pattern and its syndrome.
module csa_bist_controller #(
    parameter int NUM_PATTERNS = 4,
    parameter int RESP_W       = 6,
    parameter int CMP_DELAY    = 0,
    parameter int IDX_W        = 2,
    parameter int ERR_W        = 3
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              start,
    input  logic              abort,
    input  logic [RESP_W-1:0] desired_output,
    input  logic [RESP_W-1:0] cut_out,
    output logic              tpg_init,
    output logic              tpg_test,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [RESP_W-1:0] first_fail_syndrome
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(NUM_PATTERNS + CMP_DELAY) + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS + CMP_DELAY - 1);
    localparam logic [CW-1:0] DLY  = CW'(CMP_DELAY);
    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [RESP_W-1:0] des_d;
    logic [RESP_W-1:0] syn;
    logic              in_win;
    logic              miss;
    logic              go;
    logic              kill;
    logic [IDX_W-1:0]  pidx;
    // Align the TPG expectation with a CUT whose response lags by CMP_DELAY cycles.
    generate
        if (CMP_DELAY == 0) begin : g_nodly
            assign des_d  = desired_output;
            assign in_win = 1'b1;
        end else begin : g_dly
            logic [RESP_W-1:0] dl [CMP_DELAY];
            always_ff @(posedge clk) begin
                if (!init_n) begin
                    for (int i = 0; i < CMP_DELAY; i++) dl[i] <= '0;
                end else begin
                    dl[0] <= desired_output;
                    for (int i = 1; i < CMP_DELAY; i++) dl[i] <= dl[i-1];
                end
            end
            assign des_d  = dl[CMP_DELAY-1];
            assign in_win = cnt >= DLY;
        end
    endgenerate
    assign syn      = des_d ^ cut_out;
    assign miss     = in_win && |syn;
    assign pidx     = IDX_W'(cnt - DLY);
    assign go       = start && !abort && state != S_RUN;
    assign kill     = abort && state != S_IDLE;
    assign tpg_init = state != S_RUN;
    assign tpg_test = state == S_RUN;
    assign busy     = state == S_RUN;
    assign done     = state == S_DONE;
    assign pass     = done && err_count == '0;
    // Reset, session start and abort all wipe results; abort beats start.
    always_ff @(posedge clk) begin
        if (!init_n || go || kill) begin
            state               <= (init_n && go) ? S_RUN : S_IDLE;
            cnt                 <= '0;
            err_count           <= '0;
            first_fail_idx      <= '0;
            first_fail_syndrome <= '0;
        end else if (state == S_RUN) begin
            if (miss) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_fail_idx      <= pidx;
                    first_fail_syndrome <= syn;
                end
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_DONE;
        end
    end
endmodule

// File: tb/tb_csa_bist_controller.sv
// tb_csa_bist_controller: drives a combinational-CUT and a registered-CUT controller from a TPG model
// with per-pattern fault masks and checks session results against a pattern-level reference.
module tb_csa_bist_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic init_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0][5:0] mask = '0;
    localparam logic [5:0] PV [4] = '{6'h2d, 6'h12, 6'h3f, 6'h04};
    logic [1:0] tpg0 = '0, tpg1 = '0;
    logic [5:0] des0, cut0, des1, cut1;
    logic ti0, tt0, b0, d0, p0, ti1, tt1, b1, d1, p1;
    logic [2:0] e0, e1;
    logic [1:0] i0, i1;
    logic [5:0] s0, s1;
    int n_run = 0, n_fail = 0;

    always @(posedge clk) begin
        tpg0 <= ti0 ? 2'd0 : tt0 ? tpg0 + 2'd1 : tpg0;
        tpg1 <= ti1 ? 2'd0 : tt1 ? tpg1 + 2'd1 : tpg1;
        cut1 <= des1 ^ mask[tpg1];
    end
    assign des0 = PV[tpg0];
    assign cut0 = des0 ^ mask[tpg0];
    assign des1 = PV[tpg1];

    csa_bist_controller u0 (
        .clk(clk), .init_n(init_n), .start(start), .abort(abort),
        .desired_output(des0), .cut_out(cut0), .tpg_init(ti0), .tpg_test(tt0),
        .busy(b0), .done(d0), .pass(p0), .err_count(e0),
        .first_fail_idx(i0), .first_fail_syndrome(s0)
    );
    csa_bist_controller #(.CMP_DELAY(1)) u1 (
        .clk(clk), .init_n(init_n), .start(start), .abort(abort),
        .desired_output(des1), .cut_out(cut1), .tpg_init(ti1), .tpg_test(tt1),
        .busy(b1), .done(d1), .pass(p1), .err_count(e1),
        .first_fail_idx(i1), .first_fail_syndrome(s1)
    );

    typedef struct {
        logic [3:0][5:0] m;
        int              err;
        int              idx;
        logic [5:0]      syn;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Session outcome from the fault list alone: count faulty patterns, note the first.
    function automatic void ref_model(input logic [3:0][5:0] m, output int err, output int idx,
                                      output logic [5:0] syn);
        err = 0; idx = 0; syn = '0;
        for (int p = 0; p < 4; p++) begin
            if (m[p] != 6'h00) begin
                if (err == 0) begin idx = p; syn = m[p]; end
                err++;
            end
        end
        if (err > 7) err = 7;
    endfunction

    task automatic session(input string nm, input int e_err, input int e_idx, input logic [5:0] e_syn,
                           input int extra);
        int n0 = 0, n1 = 0;
        bit fin = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            start = (k == extra);
            if (b0) n0++;
            if (b1) n1++;
            if (d0 && d1) begin fin = 1; break; end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, " finished"}, int'(fin), 1);
        chk({nm, " busy0 cycles"}, n0, 4);
        chk({nm, " busy1 cycles"}, n1, 5);
        chk({nm, " err0"}, int'(e0), e_err);
        chk({nm, " err1"}, int'(e1), e_err);
        chk({nm, " idx0"}, int'(i0), e_idx);
        chk({nm, " idx1"}, int'(i1), e_idx);
        chk({nm, " syn0"}, int'(s0), int'(e_syn));
        chk({nm, " syn1"}, int'(s1), int'(e_syn));
        chk({nm, " pass0"}, int'(p0), int'(e_err == 0));
        chk({nm, " pass1"}, int'(p1), int'(e_err == 0));
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " busy"}, int'(b0), 0);
        chk({nm, " done"}, int'(d0), 0);
        chk({nm, " pass"}, int'(p0), 0);
        chk({nm, " err"}, int'(e0), 0);
        chk({nm, " idx"}, int'(i0), 0);
        chk({nm, " syn"}, int'(s0), 0);
        chk({nm, " tpg_init"}, int'(ti0), 1);
        chk({nm, " tpg_test"}, int'(tt0), 0);
        chk({nm, " busy1"}, int'(b1), 0);
        chk({nm, " err1"}, int'(e1), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        init_n = 1'b1;
        vt[0].m = '0;              vt[0].err = 0; vt[0].idx = 0; vt[0].syn = 6'h00;
        vt[1].m = '0;              vt[1].err = 1; vt[1].idx = 2; vt[1].syn = 6'h01;
        vt[1].m[2] = 6'h01;
        vt[2].m = {4{6'h3f}};      vt[2].err = 4; vt[2].idx = 0; vt[2].syn = 6'h3f;
        vt[3].m = '0;              vt[3].err = 0; vt[3].idx = 0; vt[3].syn = 6'h00;
        for (int i = 4; i < 8; i++) begin
            for (int p = 0; p < 4; p++) vt[i].m[p] = $urandom_range(0, 1) ? 6'($urandom) : 6'h00;
            ref_model(vt[i].m, vt[i].err, vt[i].idx, vt[i].syn);
        end
        for (int i = 0; i < 8; i++) begin
            mask = vt[i].m;
            session($sformatf("vec%0d", i), vt[i].err, vt[i].idx, vt[i].syn, -1);
        end
        mask = '0;
        mask[2] = 6'h01;
        session("start_in_run", 1, 2, 6'h01, 1);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk_idle("abort_done");
        start = 1'b1; abort = 1'b1;
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk_idle("start_abort");
        mask = {4{6'h3f}};
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_run err before", int'(e0), 2);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk_idle("abort_run");
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) init_n = 1'b0;
        @(negedge clk);
        chk_idle("reset_run");
        init_n = 1'b1;
        mask = '0;
        session("after_reset", 0, 0, 6'h00, -1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
